// File: rtl/mini_pkg.sv
// Shared constants and types for the MINI datapath arithmetic blocks.
// Holds the serial-subtractor state encoding and default operand width.
package mini_pkg;

  localparam int MINI_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Ports: a, b, bin in; d, bout out. Purely combinational.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, DIFF = A - B - BIN, LSB first over WIDTH cycles.
// Ports: CLK, RST_N, START, A, B, BIN in; BUSY, DONE, DIFF, BORROW, OVF, ZERO out.
module serial_subtractor
  import mini_pkg::*;
#(
  parameter int WIDTH = MINI_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW,
  output logic             OVF,
  output logic             ZERO
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic fs_d;
  logic fs_bout;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          br_d    = BIN;
          amsb_d  = A[WIDTH-1];
          bmsb_d  = B[WIDTH-1];
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // New bit enters at the top; after WIDTH shifts bit i is at i.
        res_d = {fs_d, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = fs_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = ST_DONE;
          diff_d   = res_d;
          borrow_d = fs_bout;
          zero_d   = (res_d == '0);
          ovf_d    = (amsb_q ^ bmsb_q)
                   & (res_d[WIDTH-1] ^ amsb_q);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign BUSY   = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign DONE   = (state_q == ST_DONE);
  assign DIFF   = diff_q;
  assign BORROW = borrow_q;
  assign OVF    = ovf_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Drivers push expected results; negedge monitors pop and compare on DONE.
module tb_serial_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  int   dones4;

  logic       start4, bin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, borrow4, ovf4, zero4;
  logic [3:0] diff4;

  logic       start8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, borrow8, ovf8, zero8;
  logic [7:0] diff8;

  exp_t q4[$];
  exp_t q8[$];
  exp_t m4, m8;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .START(start4),
    .A(a4), .B(b4), .BIN(bin4),
    .BUSY(busy4), .DONE(done4), .DIFF(diff4),
    .BORROW(borrow4), .OVF(ovf4), .ZERO(zero4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .START(start8),
    .A(a8), .B(b8), .BIN(bin8),
    .BUSY(busy8), .DONE(done8), .DIFF(diff8),
    .BORROW(borrow8), .OVF(ovf8), .ZERO(zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int d, input bit br,
                              input bit o, input bit z);
    exp_t e;
    e.diff = 16'(d);
    e.borrow = br;
    e.ovf = o;
    e.zero = z;
    e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t model(input int w, input int a,
                                 input int b, input int bin);
    exp_t e;
    int m, full, sa, sb, sd, d;
    m = (1 << w) - 1;
    full = a - b - bin;
    d = full & m;
    sa = (a >> (w - 1)) & 1;
    sb = (b >> (w - 1)) & 1;
    sd = (d >> (w - 1)) & 1;
    e.diff = 16'(d);
    e.borrow = (full < 0);
    e.ovf = ((sa ^ sb) & (sd ^ sa)) != 0;
    e.zero = (d == 0);
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done4) begin
      dones4++;
      if (q4.size() == 0) begin
        chk("unexpected_done4", 1, 0);
      end else begin
        m4 = q4.pop_front();
        chk("diff4", 32'(diff4), 32'(m4.diff));
        chk("borrow4", 32'(borrow4), 32'(m4.borrow));
        chk("ovf4", 32'(ovf4), 32'(m4.ovf));
        chk("zero4", 32'(zero4), 32'(m4.zero));
        chk("done_cycle4", cyc, m4.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 1, 0);
      end else begin
        m8 = q8.pop_front();
        chk("diff8", 32'(diff8), 32'(m8.diff));
        chk("borrow8", 32'(borrow8), 32'(m8.borrow));
        chk("ovf8", 32'(ovf8), 32'(m8.ovf));
        chk("zero8", 32'(zero8), 32'(m8.zero));
        chk("done_cycle8", cyc, m8.cyc);
      end
    end
  end

  task automatic issue4(input logic [3:0] a, input logic [3:0] b,
                        input logic bin, input bit push,
                        input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (busy4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("busy_timeout4", 1, 0);
    a4 = a;
    b4 = b;
    bin4 = bin;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    chk("accept4", 32'(busy4), 1);
    if (push) begin
      e.cyc = cyc + 4;
      q4.push_back(e);
    end
    start4 = 1'b0;
    a4 = 4'($urandom);
    b4 = 4'($urandom);
    bin4 = 1'($urandom);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic bin);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("busy_timeout8", 1, 0);
    a8 = a;
    b8 = b;
    bin8 = bin;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    e = model(8, int'(a), int'(b), int'(bin));
    e.cyc = cyc + 8;
    q8.push_back(e);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    bin8 = 1'($urandom);
  endtask

  initial begin
    int k, nb, d0, n;
    errors = 0;
    checks = 0;
    dones4 = 0;
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_done", 32'(done4), 0);
    chk("rst_diff", 32'(diff4), 0);
    chk("rst_borrow", 32'(borrow4), 0);
    chk("rst_ovf", 32'(ovf4), 0);
    chk("rst_zero", 32'(zero4), 0);
    chk("rst_busy8", 32'(busy8), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_done", dones4, 0);

    issue4(4'd15, 4'd2, 1'b0, 1, mk(13, 0, 0, 0));
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy4) nb++;
    end
    chk("busy_cycles", nb, 5);

    issue4(4'd1, 4'd0, 1'b1, 1, mk(0, 0, 0, 1));
    issue4(4'd1, 4'd1, 1'b1, 1, mk(15, 1, 0, 0));
    issue4(4'd8, 4'd1, 1'b0, 1, mk(7, 0, 1, 0));
    issue4(4'd7, 4'd8, 1'b0, 1, mk(15, 1, 1, 0));

    n = 0;
    @(negedge clk);
    while (busy4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    a4 = 4'd3; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    m4 = mk(2, 0, 0, 0);
    m4.cyc = k + 4;
    q4.push_back(m4);
    m4 = mk(5, 0, 1, 0);
    m4.cyc = k + 10;
    q4.push_back(m4);
    a4 = 4'd9; b4 = 4'd4;
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_accept", 32'(busy4), 1);
    start4 = 1'b0;

    issue4(4'd6, 4'd3, 1'b0, 1, mk(3, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    a4 = 4'd0; b4 = 4'd5; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;

    issue4(4'd13, 4'd2, 1'b0, 0, mk(0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    d0 = dones4;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy4), 0);
    chk("midrst_done", 32'(done4), 0);
    chk("midrst_diff", 32'(diff4), 0);
    chk("midrst_borrow", 32'(borrow4), 0);
    chk("midrst_ovf", 32'(ovf4), 0);
    chk("midrst_zero", 32'(zero4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_done_after_rst", dones4 - d0, 0);
    issue4(4'd13, 4'd2, 1'b0, 1, mk(11, 0, 0, 0));

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          issue4(4'(a), 4'(b), 1'(c), 1, model(4, a, b, c));

    issue8(8'd0, 8'd0, 1'b0);
    issue8(8'd0, 8'd0, 1'b1);
    issue8(8'h80, 8'h01, 1'b0);
    issue8(8'h7f, 8'hff, 1'b0);
    for (int i = 0; i < 24; i++)
      issue8(8'($urandom), 8'($urandom), 1'($urandom));

    n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain4", q4.size(), 0);
    chk("drain8", q8.size(), 0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
